// File: rtl/z80_bus_trace.sv
// Z80 bus tracer: samples the CPU bus on each rising CPU clock seen in the eclk domain and
// queues typed records in a FWFT FIFO. Define Z80_BUS_TRACE_TIMESTAMP_EN to add a per-record tick stamp (trc_ts).
module z80_bus_trace #(
    parameter int AW     = 16,
    parameter int DW     = 8,
    parameter int DEPTH  = 16,
    parameter int DROP_W = 8
) (
    input  logic                    eclk,
    input  logic                    _ereset,
    input  logic                    clk,
    input  logic                    _reset,
    input  logic                    _m1,
    input  logic                    _rd,
    input  logic                    _wr,
    input  logic                    _mreq,
    input  logic                    _iorq,
    input  logic                    _halt,
    input  logic [AW-1:0]           ab,
    input  logic [DW-1:0]           db_i,
    input  logic [DW-1:0]           db_o,
    input  logic                    enable,
    output logic                    trc_valid,
    input  logic                    trc_ready,
    output logic [2:0]              trc_type,
    output logic [AW-1:0]           trc_addr,
    output logic [DW-1:0]           trc_data,
`ifdef Z80_BUS_TRACE_TIMESTAMP_EN
    output logic [15:0]             trc_ts,
`endif
    output logic [$clog2(DEPTH):0]  count,
    output logic [DROP_W-1:0]       drops,
    output logic                    overflow,
    output logic                    halted
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    localparam logic [2:0] EV_RST_ON  = 3'd0;
    localparam logic [2:0] EV_RST_OFF = 3'd1;
    localparam logic [2:0] EV_FETCH   = 3'd2;
    localparam logic [2:0] EV_MEM_RD  = 3'd3;
    localparam logic [2:0] EV_IO_RD   = 3'd4;
    localparam logic [2:0] EV_MEM_WR  = 3'd5;
    localparam logic [2:0] EV_IO_WR   = 3'd6;
    localparam logic [2:0] EV_HALT    = 3'd7;

    localparam logic [DROP_W+3:0] DROP_MAX = {4'b0000, {DROP_W{1'b1}}};

    logic                r_clk_q;
    logic                r_rd_last;
    logic                r_wr_last;
    logic                r_reset_last;
    logic [PW-1:0]       r_wr_ptr;
    logic [PW-1:0]       r_rd_ptr;
    logic [CW-1:0]       r_count;
    logic [DROP_W-1:0]   r_drops;
    logic                r_overflow;
    logic                r_halted;

    logic [2:0]          r_mem_type [DEPTH];
    logic [AW-1:0]       r_mem_addr [DEPTH];
    logic [DW-1:0]       r_mem_data [DEPTH];

    logic                w_tick;
    logic                w_rd_fall;
    logic                w_wr_fall;
    logic [7:0]          w_ev;
    logic [3:0]          w_ev_cnt;
    logic [2:0]          w_code;
    logic [DW-1:0]       w_rec_data;
    logic                w_capture;
    logic                w_push_req;
    logic                w_full;
    logic                w_pop;
    logic                w_push;
    logic                w_full_drop;
    logic [3:0]          w_drop_inc;
    logic [DROP_W+3:0]   w_drop_sum;
    logic [DROP_W-1:0]   w_drops_next;

    // The CPU clock is only a sampled level here; its rising edge becomes a one-cycle tick.
    assign w_tick    = clk & ~r_clk_q;
    assign w_rd_fall = r_rd_last & ~_rd;
    assign w_wr_fall = r_wr_last & ~_wr;

    assign w_ev[EV_HALT]    = ~_halt;
    assign w_ev[EV_RST_ON]  = r_reset_last & ~_reset;
    assign w_ev[EV_RST_OFF] = ~r_reset_last & _reset;
    assign w_ev[EV_FETCH]   = w_rd_fall & ~_mreq & ~_m1;
    assign w_ev[EV_MEM_RD]  = w_rd_fall & ~_mreq & _m1;
    assign w_ev[EV_IO_RD]   = w_rd_fall & ~_iorq;
    assign w_ev[EV_MEM_WR]  = w_wr_fall & ~_mreq;
    assign w_ev[EV_IO_WR]   = w_wr_fall & ~_iorq;

    always_comb begin
        w_ev_cnt = '0;
        for (int i = 0; i < 8; i++) begin
            w_ev_cnt = w_ev_cnt + {3'b000, w_ev[i]};
        end
    end

    // Halt outranks everything, then reset edges, then read classes, then writes.
    always_comb begin
        w_code = EV_RST_ON;
        if (w_ev[EV_HALT])         w_code = EV_HALT;
        else if (w_ev[EV_RST_ON])  w_code = EV_RST_ON;
        else if (w_ev[EV_RST_OFF]) w_code = EV_RST_OFF;
        else if (w_ev[EV_FETCH])   w_code = EV_FETCH;
        else if (w_ev[EV_MEM_RD])  w_code = EV_MEM_RD;
        else if (w_ev[EV_IO_RD])   w_code = EV_IO_RD;
        else if (w_ev[EV_MEM_WR])  w_code = EV_MEM_WR;
        else if (w_ev[EV_IO_WR])   w_code = EV_IO_WR;
    end

    always_comb begin
        w_rec_data = '0;
        case (w_code)
            EV_FETCH, EV_MEM_RD, EV_IO_RD: w_rec_data = db_i;
            EV_MEM_WR, EV_IO_WR:           w_rec_data = db_o;
            default:                       w_rec_data = '0;
        endcase
    end

    assign w_capture   = w_tick & enable & ~r_halted;
    assign w_push_req  = w_capture & (|w_ev);
    assign w_full      = (r_count == CW'(DEPTH));
    assign w_pop       = trc_valid & trc_ready;
    assign w_push      = w_push_req & (~w_full | w_pop);
    assign w_full_drop = w_push_req & w_full & ~w_pop;

    // Losers of the priority race plus a record refused by a full FIFO.
    always_comb begin
        w_drop_inc = '0;
        if (w_push_req) begin
            w_drop_inc = w_ev_cnt - 4'd1;
        end
        if (w_full_drop) begin
            w_drop_inc = w_drop_inc + 4'd1;
        end
    end

    assign w_drop_sum = {4'b0000, r_drops} + {{DROP_W{1'b0}}, w_drop_inc};

    always_comb begin
        w_drops_next = w_drop_sum[DROP_W-1:0];
        if (w_drop_sum > DROP_MAX) begin
            w_drops_next = {DROP_W{1'b1}};
        end
    end

    always_ff @(posedge eclk or negedge _ereset) begin
        if (!_ereset) begin
            r_clk_q      <= 1'b0;
            r_rd_last    <= 1'b1;
            r_wr_last    <= 1'b1;
            r_reset_last <= 1'b1;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_drops      <= '0;
            r_overflow   <= 1'b0;
            r_halted     <= 1'b0;
        end else begin
            r_clk_q <= clk;
            if (w_tick) begin
                r_rd_last    <= _rd;
                r_wr_last    <= _wr;
                r_reset_last <= _reset;
            end
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
            if (w_drop_inc != 4'd0) begin
                r_drops    <= w_drops_next;
                r_overflow <= 1'b1;
            end
            if (w_push_req && w_ev[EV_HALT]) begin
                r_halted <= 1'b1;
            end
        end
    end

    always_ff @(posedge eclk) begin
        if (w_push) begin
            r_mem_type[r_wr_ptr] <= w_code;
            r_mem_addr[r_wr_ptr] <= ab;
            r_mem_data[r_wr_ptr] <= w_rec_data;
        end
    end

    // Head fields read as zero while empty so they are defined straight out of reset.
    assign trc_valid = (r_count != '0);
    assign trc_type  = trc_valid ? r_mem_type[r_rd_ptr] : 3'd0;
    assign trc_addr  = trc_valid ? r_mem_addr[r_rd_ptr] : '0;
    assign trc_data  = trc_valid ? r_mem_data[r_rd_ptr] : '0;
    assign count     = r_count;
    assign drops     = r_drops;
    assign overflow  = r_overflow;
    assign halted    = r_halted;

`ifdef Z80_BUS_TRACE_TIMESTAMP_EN
    logic [15:0] r_ts;
    logic [15:0] r_mem_ts [DEPTH];

    always_ff @(posedge eclk or negedge _ereset) begin
        if (!_ereset) begin
            r_ts <= '0;
        end else if (w_tick) begin
            r_ts <= r_ts + 16'd1;
        end
    end

    always_ff @(posedge eclk) begin
        if (w_push) begin
            r_mem_ts[r_wr_ptr] <= r_ts;
        end
    end

    assign trc_ts = trc_valid ? r_mem_ts[r_rd_ptr] : 16'd0;
`endif

endmodule

// File: tb/tb_z80_bus_trace.sv
// Scoreboard bench for z80_bus_trace: a cycle-level reference model queues expected records,
// a separate monitor pops and compares them as the DUT hands them out.
`timescale 1ns/1ps
module tb_z80_bus_trace;
    localparam int AW     = 16;
    localparam int DW     = 8;
    localparam int DEPTH  = 16;
    localparam int DROP_W = 8;
    localparam int DROP_SAT = (1 << DROP_W) - 1;

    logic eclk = 1'b0;
    logic _ereset = 1'b0;
    logic clk = 1'b0;
    logic _reset = 1'b1, _m1 = 1'b1, _rd = 1'b1, _wr = 1'b1;
    logic _mreq = 1'b1, _iorq = 1'b1, _halt = 1'b1;
    logic [AW-1:0] ab = '0;
    logic [DW-1:0] db_i = '0, db_o = '0;
    logic enable = 1'b0;
    logic trc_ready = 1'b0;

    logic trc_valid;
    logic [2:0] trc_type;
    logic [AW-1:0] trc_addr;
    logic [DW-1:0] trc_data;
    logic [$clog2(DEPTH):0] count;
    logic [DROP_W-1:0] drops;
    logic overflow, halted;
`ifdef Z80_BUS_TRACE_TIMESTAMP_EN
    logic [15:0] trc_ts;
`endif

    z80_bus_trace #(.AW(AW), .DW(DW), .DEPTH(DEPTH), .DROP_W(DROP_W)) dut (
        .eclk(eclk), ._ereset(_ereset), .clk(clk),
        ._reset(_reset), ._m1(_m1), ._rd(_rd), ._wr(_wr),
        ._mreq(_mreq), ._iorq(_iorq), ._halt(_halt),
        .ab(ab), .db_i(db_i), .db_o(db_o), .enable(enable),
        .trc_valid(trc_valid), .trc_ready(trc_ready),
        .trc_type(trc_type), .trc_addr(trc_addr), .trc_data(trc_data),
`ifdef Z80_BUS_TRACE_TIMESTAMP_EN
        .trc_ts(trc_ts),
`endif
        .count(count), .drops(drops), .overflow(overflow), .halted(halted)
    );

    always #5 eclk = ~eclk;

    typedef struct {
        logic [2:0]    t;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic [15:0]   ts;
    } rec_t;

    rec_t exp_q[$];
    int checks = 0;
    int errors = 0;
    int n_rec = 0;

    // Reference model state
    bit m_clk_q, m_rd_last, m_wr_last, m_reset_last, m_ovf, m_halted;
    int m_count, m_drops, m_ts;

    task automatic model_clear();
        exp_q.delete();
        m_clk_q = 0; m_rd_last = 1; m_wr_last = 1; m_reset_last = 1;
        m_ovf = 0; m_halted = 0; m_count = 0; m_drops = 0; m_ts = 0;
    endtask

    // Applies the rules for the next eclk edge using the inputs currently driven.
    task automatic model_step();
        bit tick, pop;
        int codes[$];
        int lost;
        rec_t r;
        tick = clk && !m_clk_q;
        pop  = (m_count > 0) && trc_ready;
        m_clk_q = clk;
        if (tick) begin
            if (!_halt) codes.push_back(7);
            if (m_reset_last && !_reset) codes.push_back(0);
            if (!m_reset_last && _reset) codes.push_back(1);
            if (m_rd_last && !_rd) begin
                if (!_mreq && !_m1) codes.push_back(2);
                if (!_mreq && _m1)  codes.push_back(3);
                if (!_iorq)         codes.push_back(4);
            end
            if (m_wr_last && !_wr) begin
                if (!_mreq) codes.push_back(5);
                if (!_iorq) codes.push_back(6);
            end
            if (enable && !m_halted && codes.size() > 0) begin
                lost = codes.size() - 1;
                if (m_count < DEPTH || pop) begin
                    r.t  = 3'(codes[0]);
                    r.a  = ab;
                    r.d  = (codes[0] >= 2 && codes[0] <= 4) ? db_i :
                           (codes[0] >= 5 && codes[0] <= 6) ? db_o : '0;
                    r.ts = 16'(m_ts);
                    exp_q.push_back(r);
                    m_count++;
                end else begin
                    lost++;
                end
                if (codes[0] == 7) m_halted = 1;
                if (lost > 0) begin
                    m_drops = (m_drops + lost > DROP_SAT) ? DROP_SAT : m_drops + lost;
                    m_ovf = 1;
                end
            end
            m_rd_last = _rd; m_wr_last = _wr; m_reset_last = _reset;
            m_ts = (m_ts + 1) % 65536;
        end
        if (pop) m_count--;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    task automatic check_status(input string tag);
        check({tag, "_count"},    32'(count),    32'(m_count));
        check({tag, "_drops"},    32'(drops),    32'(m_drops));
        check({tag, "_overflow"}, 32'(overflow), 32'(m_ovf));
        check({tag, "_halted"},   32'(halted),   32'(m_halted));
    endtask

    task automatic cycle(input logic c);
        clk = c;
        model_step();
        @(negedge eclk);
        #1;
    endtask

    task automatic cpu_tick();
        cycle(1'b0);
        cycle(1'b1);
    endtask

    task automatic pins_idle();
        _rd = 1; _wr = 1; _mreq = 1; _iorq = 1; _m1 = 1; _halt = 1;
    endtask

    // kind: 0 fetch, 1 mem read, 2 io read, 3 mem write, 4 io write
    task automatic bus(input int kind, input logic [AW-1:0] a, input logic [DW-1:0] d);
        pins_idle();
        ab = a;
        case (kind)
            0: begin _rd = 0; _mreq = 0; _m1 = 0; db_i = d; end
            1: begin _rd = 0; _mreq = 0; db_i = d; end
            2: begin _rd = 0; _iorq = 0; db_i = d; end
            3: begin _wr = 0; _mreq = 0; db_o = d; end
            default: begin _wr = 0; _iorq = 0; db_o = d; end
        endcase
        cpu_tick();
        pins_idle();
        cpu_tick();
    endtask

    task automatic idle_ticks(input int n);
        pins_idle();
        for (int i = 0; i < n; i++) cpu_tick();
    endtask

    // Asserts _ereset between clock edges and checks the cleared state before any edge.
    task automatic ereset_pulse(input string tag);
        #2;
        _ereset = 0;
        model_clear();
        #1;
        check({tag, "_valid"},    32'(trc_valid), 32'd0);
        check({tag, "_count"},    32'(count),     32'd0);
        check({tag, "_drops"},    32'(drops),     32'd0);
        check({tag, "_overflow"}, 32'(overflow),  32'd0);
        check({tag, "_halted"},   32'(halted),    32'd0);
        @(negedge eclk);
        #1;
        clk = 0;
        pins_idle();
        _reset = 1;
        _ereset = 1;
    endtask

    // Monitor: compares every handed-out head against the scoreboard.
    initial begin
        rec_t r;
        forever begin
            @(negedge eclk);
            #2;
            if (_ereset && trc_valid && trc_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_record actual=%0d/%04h/%02h required=none",
                             trc_type, trc_addr, trc_data);
                end else begin
                    r = exp_q.pop_front();
                    n_rec++;
                    if (trc_type !== r.t || trc_addr !== r.a || trc_data !== r.d
`ifdef Z80_BUS_TRACE_TIMESTAMP_EN
                        || trc_ts !== r.ts
`endif
                    ) begin
                        errors++;
                        $display("FAIL record%0d actual=%0d/%04h/%02h required=%0d/%04h/%02h ts=%0d",
                                 n_rec, trc_type, trc_addr, trc_data, r.t, r.a, r.d, r.ts);
                    end else begin
                        $display("record %0d type=%0d addr=%04h data=%02h ok", n_rec, r.t, r.a, r.d);
                    end
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        model_clear();
        #7;
        check("rst_valid",    32'(trc_valid), 32'd0);
        check("rst_count",    32'(count),     32'd0);
        check("rst_drops",    32'(drops),     32'd0);
        check("rst_overflow", 32'(overflow),  32'd0);
        check("rst_halted",   32'(halted),    32'd0);
        check("rst_head",     {trc_type, 5'd0, trc_addr, trc_data}, 32'd0);
        @(negedge eclk);
        #1;
        _ereset = 1;
        enable = 1;
        trc_ready = 1;

        // Basic read/write classes, a held write strobe and a CPU reset pulse.
        bus(0, 16'h0000, 8'hF5);
        bus(1, 16'h1234, 8'h3E);
        bus(3, 16'hFFFE, 8'hA5);
        bus(4, 16'h00FE, 8'h07);
        bus(2, 16'h0042, 8'h99);
        pins_idle(); _wr = 0; _mreq = 0; ab = 16'h8000; db_o = 8'h5A;
        for (int i = 0; i < 3; i++) cpu_tick();
        idle_ticks(1);
        ab = 16'h0100; _reset = 0;
        for (int i = 0; i < 4; i++) cpu_tick();
        _reset = 1;
        idle_ticks(4);
        check("basic_drops", 32'(drops), 32'd0);
        check_status("basic");

        // Reset assertion coinciding with a fetch.
        pins_idle(); _reset = 0; _rd = 0; _mreq = 0; _m1 = 0; ab = 16'h0200; db_i = 8'h11;
        cpu_tick();
        pins_idle();
        cpu_tick();
        _reset = 1;
        idle_ticks(4);
        check("simul_drops", 32'(drops), 32'd1);
        check_status("simul");

        // Overflow with the consumer stalled.
        trc_ready = 0;
        for (int i = 0; i < 20; i++) bus(0, AW'(16'h3000 + i), DW'(i));
        check("ovf_count", 32'(count), 32'd16);
        check("ovf_drops", 32'(drops), 32'd5);
        check("ovf_flag",  32'(overflow), 32'd1);
        pins_idle(); _rd = 0; _mreq = 0; _m1 = 0; ab = 16'h3FFF; db_i = 8'hEE;
        cycle(1'b0);
        trc_ready = 1;
        cycle(1'b1);
        trc_ready = 0;
        check("fullpp_count", 32'(count), 32'd16);
        check("fullpp_drops", 32'(drops), 32'd5);
        trc_ready = 1;
        idle_ticks(12);
        check("drain_count", 32'(count), 32'd0);
        check_status("drain");

        // Randomised traffic against the model.
        for (int i = 0; i < 600; i++) begin
            enable = ($urandom_range(0, 7) != 0);
            _rd = 1'($urandom); _wr = 1'($urandom); _mreq = 1'($urandom);
            _iorq = 1'($urandom); _m1 = 1'($urandom);
            _reset = ($urandom_range(0, 9) != 0);
            _halt = 1;
            ab = AW'($urandom); db_i = DW'($urandom); db_o = DW'($urandom);
            trc_ready = ($urandom_range(0, 2) != 0);
            cycle(1'b0);
            trc_ready = ($urandom_range(0, 2) != 0);
            cycle(1'b1);
            if (i % 50 == 49) check_status("rand");
        end
        enable = 0; trc_ready = 1; _reset = 1;
        idle_ticks(20);
        check_status("rand_end");
        check("rand_left", 32'(exp_q.size()), 32'd0);

        // Halt capture freezes further tracing.
        ereset_pulse("mid1");
        enable = 1; trc_ready = 1;
        pins_idle(); _halt = 0; ab = 16'h0038;
        cpu_tick();
        idle_ticks(2);
        check("halt_flag", 32'(halted), 32'd1);
        for (int i = 0; i < 5; i++) bus(0, AW'(16'h0500 + i), 8'h77);
        idle_ticks(2);
        check("halt_count", 32'(count), 32'd0);
        check_status("halt");
        check("halt_left", 32'(exp_q.size()), 32'd0);

        // Asynchronous clear mid-stream.
        ereset_pulse("mid2");
        enable = 1; trc_ready = 0;
        for (int i = 0; i < 5; i++) bus(1, AW'(16'h0600 + i), DW'(8'h40 + i));
        check("pre_clr_count", 32'(count), 32'd5);
        ereset_pulse("mid3");
        enable = 1; trc_ready = 1;
        bus(0, 16'h0700, 8'hC3);
        idle_ticks(2);
        check_status("final");
        check("final_left", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/z80_bus_trace.md
Name: z80_bus_trace

Overview:
- Synthesisable, parametrised successor to the simulation-only `$display` bus logger in the Z80 test SoC.
- Runs in the `eclk` domain and samples the CPU bus on each rising edge of the CPU clock `clk`.
- Classifies bus cycles into typed trace records and buffers them in a DEPTH-entry FIFO, read out over a valid/ready port.
- Sits beside `chip_z80` and the RAM in the test SoC and feeds a host/dump port in place of text logging.

Parameters:
- AW, 16, address bus width.
- DW, 8, data bus width.
- DEPTH, 16, trace FIFO entries; power of two, minimum 2.
- DROP_W, 8, width of the saturating drop counter.

Ports:
- eclk  input  1  system clock; all state on its rising edge.
- _ereset  input  1  asynchronous active-low reset.
- clk  input  1  CPU clock, a level sampled in the eclk domain.
- _reset, _m1, _rd, _wr, _mreq, _iorq, _halt  input  1 each  CPU control pins, active-low.
- ab  input  AW  address bus.
- db_i  input  DW  data into the CPU (read data).
- db_o  input  DW  data out of the CPU (write data).
- enable  input  1  capture enable.
- trc_valid  output  1  FIFO head is valid.
- trc_ready  input  1  consumer accepts the head.
- trc_type  output  3  event code of the head record.
- trc_addr  output  AW  address of the head record.
- trc_data  output  DW  data of the head record.
- count  output  clog2(DEPTH)+1  current FIFO occupancy.
- drops  output  DROP_W  number of lost events, saturating.
- overflow  output  1  sticky: at least one event lost.
- halted  output  1  sticky: halt event captured.

Behaviour:
- Reset values:
  - clk_q = 0.
  - rd_last, wr_last, reset_last = 1.
  - FIFO empty; trc_valid = 0; count = 0; drops = 0; overflow = 0; halted = 0.
  - trc_type, trc_addr, trc_data = 0.
- Tick: tick = clk & ~clk_q, where clk_q is clk registered on eclk. All event logic runs only on a tick cycle.
- On every tick, regardless of enable or halted: rd_last <= _rd, wr_last <= _wr, reset_last <= _reset.
- Event detection on a tick, using the pin values present in that cycle:
  - Code 7, halt: _halt = 0.
  - Code 0, reset asserted: reset_last & ~_reset.
  - Code 1, reset released: ~reset_last & _reset.
  - Read falling edge (rd_last & ~_rd):
    - Code 2, fetch: ~_mreq & ~_m1.
    - Code 3, mem read: ~_mreq & _m1.
    - Code 4, io read: ~_iorq.
  - Write falling edge (wr_last & ~_wr):
    - Code 5, mem write: ~_mreq.
    - Code 6, io write: ~_iorq.
- At most one record per tick. Priority is 7 > 0 > 1 > 2 > 3 > 4 > 5 > 6.
  - Each other event detected on the same tick is counted as a drop.
- Record fields:
  - addr = ab.
  - data = db_i for codes 2–4, db_o for codes 5–6, 0 for codes 0, 1 and 7.
- Capture gating: no push, and no drop counting, when enable = 0 or halted = 1.
- Halt: pushing or dropping a code-7 event sets halted, and it stays set until _ereset. After that, no further capture occurs even if _halt deasserts.
- FIFO behaviour:
  - First-word fall-through.
  - trc_valid = (count != 0); trc_type, trc_addr and trc_data present the head record.
  - Pop occurs when trc_valid & trc_ready.
  - Latency: on an empty FIFO, a push in cycle t gives trc_valid = 1 in cycle t+1.
  - Push when full with no pop in the same cycle: the new record is discarded, drops increments (saturating at 2^DROP_W−1) and overflow is set.
  - Push and pop in the same cycle while full: both proceed; count is unchanged and nothing is dropped.
  - Push and pop in the same cycle while empty: no pop (trc_valid = 0); the push lands.
  - Read and write pointers wrap modulo DEPTH.
- Asserting _ereset mid-operation clears the FIFO and all counters immediately, without waiting for a clock.

Optional Feature:
- Macro: Z80_BUS_TRACE_TIMESTAMP_EN.
- When defined:
  - A 16-bit tick counter is added. It resets to 0, increments on every tick and wraps at 0xFFFF→0.
  - Each record also stores the counter value of its tick.
  - An extra port, trc_ts (output, 16 bits), presents the head record's timestamp.
- When undefined: no counter and no trc_ts port; all other behaviour is identical.

Test Plan:
- Read cycles: enable = 1, trc_ready = 1. Fetch with _rd falling, ~_mreq, ~_m1, ab = 0x0000, db_i = 0xF5 → one record {2, 0x0000, 0xF5}. Mem read with _m1 = 1, ab = 0x1234, db_i = 0x3E → {3, 0x1234, 0x3E}.
- Write cycles: mem write with _wr falling, ~_mreq, ab = 0xFFFE, db_o = 0xA5 → {5, 0xFFFE, 0xA5}. IO write with ~_iorq, ab = 0x00FE, db_o = 0x07 → {6, 0x00FE, 0x07}. Holding _wr low for 3 ticks produces exactly one record.
- Reset events: _reset pulsed low for 4 ticks → records {0, ab, 0} then {1, ab, 0}. A simultaneous reset assertion and fetch on one tick → only code 0 is recorded and drops = 1.
- Overflow: trc_ready = 0, DEPTH = 16, 20 fetches → count = 16, drops = 4, overflow = 1. Draining returns the first 16 records in order. A push and pop in the same cycle while full gives count = 16 and no additional drop.
- Halt: _halt driven low → record {7, ab, 0} and halted = 1. Later fetches produce no records and drops is unchanged. Asserting _ereset mid-stream → count = 0, halted = 0, drops = 0, trc_valid = 0 asynchronously.
- With Z80_BUS_TRACE_TIMESTAMP_EN defined: fetches on ticks 5 and 9 after reset release → trc_ts = 5 then 9. Running 65537 ticks shows the counter wrapping to 0.
